// File: rtl/updown_counter_param_if.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param_if
// Description : Control and status bundle for the parametrised up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface updown_counter_param_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic             sat_mode;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             wrap_pulse;
    logic             ovf;
    logic             unf;

    modport master (
        output en, dir, load, load_val, max_val, sat_mode, clr_flags,
        input  count, at_max, at_zero, wrap_pulse, ovf, unf
    );

    modport slave (
        input  en, dir, load, load_val, max_val, sat_mode, clr_flags,
        output count, at_max, at_zero, wrap_pulse, ovf, unf
    );
endinterface
`default_nettype wire

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Up/down counter with runtime limit, load, wrap/saturate mode,
//               boundary pulse and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  wire                   clk,
    input  wire                   rst,
    updown_counter_param_if.slave bus
);
    localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_up_evt;
    logic             w_dn_evt;

    always_comb begin
        w_count_nxt = r_count;
        w_up_evt    = 1'b0;
        w_dn_evt    = 1'b0;
        if (bus.load) begin
            w_count_nxt = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
        end else if (bus.en) begin
            if (bus.dir) begin
                if (r_count >= bus.max_val) begin
                    w_up_evt    = 1'b1;
                    w_count_nxt = bus.sat_mode ? bus.max_val : '0;
                end else begin
                    w_count_nxt = r_count + c_one;
                end
            end else begin
                // A limit lowered below the count pulls it back without an event.
                if (r_count > bus.max_val) begin
                    w_count_nxt = bus.max_val;
                end else if (r_count == '0) begin
                    w_dn_evt    = 1'b1;
                    w_count_nxt = bus.sat_mode ? '0 : bus.max_val;
                end else begin
                    w_count_nxt = r_count - c_one;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= c_reset_val;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_up_evt | w_dn_evt;
            // Setting takes precedence over a same-edge clear.
            r_ovf   <= w_up_evt | (r_ovf & ~bus.clr_flags);
            r_unf   <= w_dn_evt | (r_unf & ~bus.clr_flags);
        end
    end

    assign bus.count      = r_count;
    assign bus.at_max     = (r_count >= bus.max_val);
    assign bus.at_zero    = (r_count == '0);
    assign bus.wrap_pulse = r_wrap;
    assign bus.ovf        = r_ovf;
    assign bus.unf        = r_unf;
endmodule
`default_nettype wire
